// File: rtl/alu_arb_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : alu_arb_if                                                  |
// | Brief   : Request/response bundle between two ALU clients and alu_arb |
// | Rev     : 1.0  initial release                                        |
// +-----------------------------------------------------------------------+
interface alu_arb_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int INSTR_WIDTH = 4
);
  logic                   flush;

  logic                   req0_valid;
  logic                   req0_ready;
  logic [DATA_WIDTH-1:0]  req0_rs1;
  logic [DATA_WIDTH-1:0]  req0_rs2;
  logic [INSTR_WIDTH-1:0] req0_op;
  logic                   rsp0_valid;
  logic [DATA_WIDTH-1:0]  rsp0_data;

  logic                   req1_valid;
  logic                   req1_ready;
  logic [DATA_WIDTH-1:0]  req1_rs1;
  logic [DATA_WIDTH-1:0]  req1_rs2;
  logic [INSTR_WIDTH-1:0] req1_op;
  logic                   rsp1_valid;
  logic [DATA_WIDTH-1:0]  rsp1_data;

  // Requesters and pipeline control.
  modport master (
    output flush,
    output req0_valid, req0_rs1, req0_rs2, req0_op,
    input  req0_ready, rsp0_valid, rsp0_data,
    output req1_valid, req1_rs1, req1_rs2, req1_op,
    input  req1_ready, rsp1_valid, rsp1_data
  );

  // Arbiter side.
  modport slave (
    input  flush,
    input  req0_valid, req0_rs1, req0_rs2, req0_op,
    output req0_ready, rsp0_valid, rsp0_data,
    input  req1_valid, req1_rs1, req1_rs2, req1_op,
    output req1_ready, rsp1_valid, rsp1_data
  );
endinterface
`default_nettype wire

// File: rtl/alu_arb.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : alu_arb                                                     |
// | Brief   : Two-port arbiter sharing one registered ALU, 1-cycle result |
// |           return. Define ALU_ARB_FIXED_PRIO_EN for fixed priority     |
// |           (port 0 wins); default is round-robin.                      |
// | Rev     : 1.0  initial release                                        |
// +-----------------------------------------------------------------------+
module alu_arb #(
  parameter int DATA_WIDTH  = 32,
  parameter int INSTR_WIDTH = 4
) (
  input  wire                    clk,
  input  wire                    rst_n,
  alu_arb_if.slave               bus,
  output logic [DATA_WIDTH-1:0]  alu_rs1,
  output logic [DATA_WIDTH-1:0]  alu_rs2,
  output logic [INSTR_WIDTH-1:0] alu_op,
  input  wire  [DATA_WIDTH-1:0]  alu_rd
);

  logic inflight_q, inflight_d;
  logic owner_q, owner_d;
  logic gnt0, gnt1;
  logic xfer0, xfer1;

`ifndef ALU_ARB_FIXED_PRIO_EN
  logic last_q, last_d;
`endif

  // Grant is suppressed during reset and flush so nothing enters the ALU.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n && !bus.flush) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      if (bus.req0_valid)      gnt0 = 1'b1;
      else if (bus.req1_valid) gnt1 = 1'b1;
`else
      if (bus.req0_valid && bus.req1_valid) begin
        gnt0 = last_q;
        gnt1 = !last_q;
      end else if (bus.req0_valid) begin
        gnt0 = 1'b1;
      end else if (bus.req1_valid) begin
        gnt1 = 1'b1;
      end
`endif
    end
  end

  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;
  assign xfer0 = bus.req0_valid & gnt0;
  assign xfer1 = bus.req1_valid & gnt1;

  always_comb begin
    alu_rs1 = '0;
    alu_rs2 = '0;
    alu_op  = '0;
    if (xfer0) begin
      alu_rs1 = bus.req0_rs1;
      alu_rs2 = bus.req0_rs2;
      alu_op  = bus.req0_op;
    end else if (xfer1) begin
      alu_rs1 = bus.req1_rs1;
      alu_rs2 = bus.req1_rs2;
      alu_op  = bus.req1_op;
    end
  end

  always_comb begin
    inflight_d = xfer0 | xfer1;
    owner_d    = xfer1;
`ifndef ALU_ARB_FIXED_PRIO_EN
    last_d     = (xfer0 | xfer1) ? xfer1 : last_q;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= 1'b0;
      owner_q    <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_q     <= 1'b1;
`endif
    end else begin
      inflight_q <= inflight_d;
      owner_q    <= owner_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_q     <= last_d;
`endif
    end
  end

  // The ALU result register is unreset; only inflight_q makes it visible.
  assign bus.rsp0_valid = inflight_q & !owner_q & !bus.flush;
  assign bus.rsp1_valid = inflight_q &  owner_q & !bus.flush;
  assign bus.rsp0_data  = alu_rd;
  assign bus.rsp1_data  = alu_rd;

endmodule
`default_nettype wire

// File: tb/tb_alu_arb.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : tb_alu_arb                                                  |
// | Brief   : Directed table-driven bench for alu_arb with a local ALU    |
// | Rev     : 1.0  initial release                                        |
// +-----------------------------------------------------------------------+
module tb_alu_arb;
  localparam int DW = 32;
  localparam int IW = 4;

  localparam logic [IW-1:0] OP_ADD  = 4'd0;
  localparam logic [IW-1:0] OP_SUB  = 4'd1;
  localparam logic [IW-1:0] OP_XOR  = 4'd2;
  localparam logic [IW-1:0] OP_SLT  = 4'd3;
  localparam logic [IW-1:0] OP_SLTU = 4'd4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] alu_rs1, alu_rs2, alu_rd;
  logic [IW-1:0] alu_op;

  alu_arb_if #(.DATA_WIDTH(DW), .INSTR_WIDTH(IW)) bus ();

  alu_arb #(.DATA_WIDTH(DW), .INSTR_WIDTH(IW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .alu_rs1 (alu_rs1),
    .alu_rs2 (alu_rs2),
    .alu_op  (alu_op),
    .alu_rd  (alu_rd)
  );

  always #5 clk = ~clk;

  // Registered ALU with no reset on its result, like the real one.
  always_ff @(posedge clk) begin
    case (alu_op)
      OP_ADD:  alu_rd <= alu_rs1 + alu_rs2;
      OP_SUB:  alu_rd <= alu_rs1 - alu_rs2;
      OP_XOR:  alu_rd <= alu_rs1 ^ alu_rs2;
      OP_SLT:  alu_rd <= {31'd0, $signed(alu_rs1) < $signed(alu_rs2)};
      OP_SLTU: alu_rd <= {31'd0, alu_rs1 < alu_rs2};
      default: alu_rd <= '0;
    endcase
  end

  typedef struct {
    logic          rst;
    logic          flush;
    logic          v0;
    logic [DW-1:0] a0, b0;
    logic [IW-1:0] op0;
    logic          v1;
    logic [DW-1:0] a1, b1;
    logic [IW-1:0] op1;
    logic          e_rdy0, e_rdy1, e_v0, e_v1;
    logic [DW-1:0] e_data;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add(input logic rst, input logic flush,
                     input logic v0, input logic [DW-1:0] a0, input logic [DW-1:0] b0, input logic [IW-1:0] op0,
                     input logic v1, input logic [DW-1:0] a1, input logic [DW-1:0] b1, input logic [IW-1:0] op1,
                     input logic e_rdy0, input logic e_rdy1, input logic e_v0, input logic e_v1,
                     input logic [DW-1:0] e_data);
    vec_t v;
    v.rst = rst; v.flush = flush;
    v.v0 = v0; v.a0 = a0; v.b0 = b0; v.op0 = op0;
    v.v1 = v1; v.a1 = a1; v.b1 = b1; v.op1 = op1;
    v.e_rdy0 = e_rdy0; v.e_rdy1 = e_rdy1; v.e_v0 = e_v0; v.e_v1 = e_v1;
    v.e_data = e_data;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input int row, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL row %0d %s: got %0h expected %0h", row, name, act, exp);
    end
  endtask

  initial begin
    logic [DW-1:0] e_rs1, e_rs2;
    logic [IW-1:0] e_op;

    rst_n = 1'b0;
    bus.flush = 1'b0;
    bus.req0_valid = 1'b0; bus.req0_rs1 = '0; bus.req0_rs2 = '0; bus.req0_op = '0;
    bus.req1_valid = 1'b0; bus.req1_rs1 = '0; bus.req1_rs2 = '0; bus.req1_op = '0;

    //   rst fl  v0 a0 b0 op0   v1 a1 b1 op1       rdy0 rdy1 v0 v1 data
    add(1, 0,  0, 0, 0, OP_ADD, 0, 0, 0, OP_ADD,   0, 0, 0, 0, 0);
    add(0, 0,  0, 0, 0, OP_ADD, 0, 0, 0, OP_ADD,   0, 0, 0, 0, 0);
    // single request on port 0
    add(0, 0,  1, 5, 7, OP_ADD, 0, 0, 0, OP_ADD,   1, 0, 0, 0, 0);
    add(0, 0,  0, 0, 0, OP_ADD, 0, 0, 0, OP_ADD,   0, 0, 1, 0, 12);
    add(0, 0,  0, 0, 0, OP_ADD, 0, 0, 0, OP_ADD,   0, 0, 0, 0, 0);
    // reset restores port 0 as the contention winner
    add(1, 0,  0, 0, 0, OP_ADD, 0, 0, 0, OP_ADD,   0, 0, 0, 0, 0);
`ifdef ALU_ARB_FIXED_PRIO_EN
    add(0, 0,  1, 10, 3, OP_SUB, 1, 32'hF0, 32'h0F, OP_XOR,  1, 0, 0, 0, 0);
    add(0, 0,  1, 10, 3, OP_SUB, 1, 32'hF0, 32'h0F, OP_XOR,  1, 0, 1, 0, 7);
    add(0, 0,  1, 10, 3, OP_SUB, 1, 32'hF0, 32'h0F, OP_XOR,  1, 0, 1, 0, 7);
    add(0, 0,  1, 10, 3, OP_SUB, 1, 32'hF0, 32'h0F, OP_XOR,  1, 0, 1, 0, 7);
    add(0, 0,  0, 0, 0, OP_ADD,  1, 32'hF0, 32'h0F, OP_XOR,  0, 1, 1, 0, 7);
`else
    add(0, 0,  1, 10, 3, OP_SUB, 1, 32'hF0, 32'h0F, OP_XOR,  1, 0, 0, 0, 0);
    add(0, 0,  1, 10, 3, OP_SUB, 1, 32'hF0, 32'h0F, OP_XOR,  0, 1, 1, 0, 7);
    add(0, 0,  1, 10, 3, OP_SUB, 1, 32'hF0, 32'h0F, OP_XOR,  1, 0, 0, 1, 32'hFF);
    add(0, 0,  1, 10, 3, OP_SUB, 1, 32'hF0, 32'h0F, OP_XOR,  0, 1, 1, 0, 7);
    add(0, 0,  0, 0, 0, OP_ADD,  1, 32'hF0, 32'h0F, OP_XOR,  0, 1, 0, 1, 32'hFF);
`endif
    // back-to-back on port 1: SLT(-1,1)=1, SLTU(max,1)=0
    add(0, 0,  0, 0, 0, OP_ADD, 1, 32'hFFFF_FFFF, 1, OP_SLT,   0, 1, 0, 1, 32'hFF);
    add(0, 0,  0, 0, 0, OP_ADD, 1, 32'hFFFF_FFFF, 1, OP_SLTU,  0, 1, 0, 1, 1);
    add(0, 0,  0, 0, 0, OP_ADD, 0, 0, 0, OP_ADD,               0, 0, 0, 1, 0);
    // flush kills the pending port 0 response and blocks port 1 for a cycle
    add(0, 0,  1, 1, 1, OP_ADD, 0, 0, 0, OP_ADD,   1, 0, 0, 0, 0);
    add(0, 1,  0, 0, 0, OP_ADD, 1, 2, 3, OP_ADD,   0, 0, 0, 0, 0);
    add(0, 0,  0, 0, 0, OP_ADD, 1, 2, 3, OP_ADD,   0, 1, 0, 0, 0);
    add(0, 0,  0, 0, 0, OP_ADD, 0, 0, 0, OP_ADD,   0, 0, 0, 1, 5);
    // reset while an operation is in flight
    add(0, 0,  1, 4, 4, OP_ADD, 0, 0, 0, OP_ADD,   1, 0, 0, 0, 0);
    add(1, 0,  1, 4, 4, OP_ADD, 1, 9, 9, OP_ADD,   0, 0, 0, 0, 0);
    add(0, 0,  0, 0, 0, OP_ADD, 0, 0, 0, OP_ADD,   0, 0, 0, 0, 0);
    add(0, 0,  1, 1, 2, OP_ADD, 1, 3, 4, OP_ADD,   1, 0, 0, 0, 0);
    add(0, 0,  0, 0, 0, OP_ADD, 1, 3, 4, OP_ADD,   0, 1, 1, 0, 3);
    add(0, 0,  0, 0, 0, OP_ADD, 0, 0, 0, OP_ADD,   0, 0, 0, 1, 7);
    // flush with both requesting grants nothing
    add(0, 1,  1, 1, 1, OP_ADD, 1, 1, 1, OP_ADD,   0, 0, 0, 0, 0);
    add(0, 0,  0, 0, 0, OP_ADD, 0, 0, 0, OP_ADD,   0, 0, 0, 0, 0);

    repeat (2) @(posedge clk);

    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk);
      #1;
      rst_n          = !tbl[i].rst;
      bus.flush      = tbl[i].flush;
      bus.req0_valid = tbl[i].v0;
      bus.req0_rs1   = tbl[i].a0;
      bus.req0_rs2   = tbl[i].b0;
      bus.req0_op    = tbl[i].op0;
      bus.req1_valid = tbl[i].v1;
      bus.req1_rs1   = tbl[i].a1;
      bus.req1_rs2   = tbl[i].b1;
      bus.req1_op    = tbl[i].op1;
      @(negedge clk);

      chk("req0_ready", i, {31'd0, bus.req0_ready}, {31'd0, tbl[i].e_rdy0});
      chk("req1_ready", i, {31'd0, bus.req1_ready}, {31'd0, tbl[i].e_rdy1});
      chk("rsp0_valid", i, {31'd0, bus.rsp0_valid}, {31'd0, tbl[i].e_v0});
      chk("rsp1_valid", i, {31'd0, bus.rsp1_valid}, {31'd0, tbl[i].e_v1});
      if (tbl[i].e_v0) chk("rsp0_data", i, bus.rsp0_data, tbl[i].e_data);
      if (tbl[i].e_v1) chk("rsp1_data", i, bus.rsp1_data, tbl[i].e_data);

      e_rs1 = '0; e_rs2 = '0; e_op = '0;
      if (tbl[i].e_rdy0) begin
        e_rs1 = tbl[i].a0; e_rs2 = tbl[i].b0; e_op = tbl[i].op0;
      end else if (tbl[i].e_rdy1) begin
        e_rs1 = tbl[i].a1; e_rs2 = tbl[i].b1; e_op = tbl[i].op1;
      end
      chk("alu_rs1", i, alu_rs1, e_rs1);
      chk("alu_rs2", i, alu_rs2, e_rs2);
      chk("alu_op",  i, {28'd0, alu_op}, {28'd0, e_op});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/alu_arb.md
Name: alu_arb

Overview:
- Two-port round-robin arbiter that shares one registered integer ALU between two requesters, e.g. the main issue path and a multi-cycle address/branch helper.
- Accepts at most one operation per cycle and drives the ALU operand and opcode inputs.
- Tracks which port owns the in-flight operation and returns the ALU result to that port one cycle later.
- Fully pipelined: throughput of one operation per cycle.

Parameters:
DATA_WIDTH, 32, operand/result width; must match the ALU.
INSTR_WIDTH, 4, ALU opcode width; must match the ALU.

Ports:
clk  in  1  clock; all state updates on posedge.
rst_n  in  1  asynchronous, active-low reset.
flush  in  1  pipeline flush: blocks grants and kills the response due this cycle.
req0_valid  in  1  port 0 has an operation.
req0_ready  out  1  port 0 operation accepted this cycle.
req0_rs1  in  DATA_WIDTH  port 0 operand 1.
req0_rs2  in  DATA_WIDTH  port 0 operand 2.
req0_op  in  INSTR_WIDTH  port 0 ALU opcode.
rsp0_valid  out  1  port 0 result valid; no backpressure.
rsp0_data  out  DATA_WIDTH  port 0 result.
req1_valid, req1_ready, req1_rs1, req1_rs2, req1_op, rsp1_valid, rsp1_data: same directions, widths and meanings for port 1.
alu_rs1  out  DATA_WIDTH  ALU operand 1.
alu_rs2  out  DATA_WIDTH  ALU operand 2.
alu_op  out  INSTR_WIDTH  ALU opcode.
alu_rd  in  DATA_WIDTH  ALU registered result; valid one cycle after operands are presented.

Behaviour:
- Reset (async, rst_n=0):
  - inflight_q=0, owner_q=0, last_q=1, so port 0 wins the first contention.
  - rsp0_valid=rsp1_valid=0; req0_ready=req1_ready=0 while rst_n=0.
  - rsp*_data content is don't-care while the matching rsp*_valid=0.
- Grant (combinational, cycle T):
  - flush=1: no grant.
  - Only one port valid: grant that port.
  - Both valid: grant the port not equal to last_q.
  - reqN_ready=1 only for the granted port. Transfer = reqN_valid & reqN_ready.
- ALU drive (combinational, cycle T):
  - Transfer: alu_rs1/alu_rs2/alu_op = granted port's rs1/rs2/op.
  - No transfer: all ALU inputs = 0 (ADD of 0,0). The result is never forwarded.
- State update on posedge ending cycle T:
  - inflight_q <= transfer; owner_q <= granted port.
  - last_q <= granted port, updated only on a transfer.
- Response (cycle T+1):
  - rspN_valid = inflight_q & (owner_q==N) & !flush.
  - rspN_data = alu_rd (both ports may see alu_rd; only valid qualifies it).
  - Latency: exactly 1 cycle from accept to response.
  - Never more than one rsp*_valid high in a cycle.
- Back-to-back: a new accept may occur in the same cycle as a response; owner_q/inflight_q are overwritten, no bubble.
- Flush:
  - flush=1 in cycle T suppresses any rsp*_valid in T and blocks the grant in T.
  - inflight_q is 0 at T+1 (nothing was accepted).
  - last_q is unchanged.
  - Requesters must hold valid; they are served after flush drops.
- Reset mid-operation: the in-flight result is discarded; no response is issued after reset release until a new accept.
- Requests are not required to be stable while not ready; the arbiter samples only on transfer.
- The ALU has no reset of its result register. The arbiter never exposes alu_rd without inflight_q, so stale ALU content is never visible.

Optional Feature:
- Macro: ALU_ARB_FIXED_PRIO_EN.
- Defined: fixed priority. Port 0 always wins contention; last_q is not implemented and port 1 is granted only when req0_valid=0 or port 0 is idle. All other behaviour is identical.
- Undefined: round-robin as described above.

Test Plan:
- Port 0 only: op=ADD, rs1=5, rs2=7 in cycle T -> req0_ready=1 in T; rsp0_valid=1, rsp0_data=12 in T+1; rsp1_valid=0 throughout.
- Both valid continuously for 4 cycles after reset, port0 SUB 10-3, port1 XOR 0xF0^0x0F -> grants 0,1,0,1; responses alternate rsp0=7, rsp1=0xFF, each exactly one cycle after its grant.
- Back-to-back on port 1: SLT(-1,1), then SLTU(0xFFFFFFFF,1) in consecutive cycles -> rsp1_data=1 then 0 on consecutive cycles with no bubble.
- Flush: accept port0 ADD(1,1) in T, flush=1 in T+1 -> rsp0_valid=0 in T+1, both ready=0 in T+1; port1 held valid is granted in T+2 and responds in T+3.
- Reset mid-flight: accept in T, rst_n low during T+1 -> no rsp*_valid in T+1 or after release until a new accept; after release, contention grants port 0 first.
- With ALU_ARB_FIXED_PRIO_EN: both valid for 3 cycles -> port 0 granted all 3; port 1 granted in the first cycle req0_valid=0.
